overture_program_loader: RTL and testbench
==========================================

Name: overture_program_loader

Overview:
Writer side of the Overture program store. The CPU's fetch unit reads instructions combinationally by PC; this block owns the 256x8 program memory, fills it from a framed byte stream (valid/ready), and gates the CPU's run and reset signals so the CPU only executes a fully received, checksum-verified program. Sits between a host byte source (UART receiver, test bench) and overture_cpu.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker recognised in IDLE
TIMEOUT, 1023, max cycles between accepted bytes inside a frame before abort (counter width sized to hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
rx_valid  input  1  host byte valid
rx_data  input  8  host byte
rx_ready  output  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready at a rising clk edge
fetch_addr  input  8  CPU PC
fetch_data  output  8  mem[fetch_addr], combinational read, zero latency
run_en  input  1  host permission to run
cpu_run  output  1  drives CPU run; = prog_valid & run_en & (state==IDLE)
cpu_reset  output  1  active-high one-cycle pulse to CPU reset after a good load
prog_valid  output  1  memory holds a verified program
busy  output  1  high in LEN, DATA, CSUM, START
load_err  output  1  sticky error flag; cleared when the next SYNC_BYTE is accepted

Behaviour:
- Reset (reset==0, async): state=IDLE, addr=0, remaining=0, sum=0, timer=0. Outputs: prog_valid=0, load_err=0, cpu_reset=0, busy=0, rx_ready=1, cpu_run=0. Memory contents are not reset; a partial program may survive, and prog_valid=0 keeps the CPU halted.
- States: IDLE, LEN, DATA, CSUM, START.
- IDLE: rx_ready=1. Accepted byte != SYNC_BYTE is discarded. Accepted SYNC_BYTE: load_err<=0, prog_valid<=0 (cpu_run drops the next cycle), addr<=0, sum<=0, go to LEN.
- LEN: accepted byte L. remaining<=L, with L==0 meaning 256 (9-bit counter). Go to DATA. The length byte is not summed.
- DATA: each accepted byte is written the same edge: mem[addr]<=byte, sum<=sum+byte (mod 256), addr<=addr+1 (8-bit, wraps 255->0 only on a 256-byte frame), remaining<=remaining-1. When the last byte is accepted (remaining==1), go to CSUM. SYNC_BYTE values in DATA are payload, not a resync.
- CSUM: accepted byte C. If (sum+C) mod 256 == 0: go to START, prog_valid<=1. Otherwise load_err<=1, prog_valid stays 0, go to IDLE.
- START: exactly one cycle. cpu_reset=1, rx_ready=0, then IDLE. cpu_run may go high from the first IDLE cycle after START, so the CPU's reset and run are never both active in the same cycle.
- Timeout: timer clears on every accepted byte and on entry to LEN. It increments each cycle in LEN, DATA, or CSUM without an accepted byte. When timer==TIMEOUT: load_err<=1, prog_valid=0, state<=IDLE. Memory keeps the bytes written so far.
- Write/read same address same cycle: fetch_data shows the old value until the edge. The CPU is halted in that case anyway.
- A frame received while prog_valid=1 invalidates the old program as soon as its SYNC_BYTE is accepted.
- Asserting reset mid-frame aborts immediately to reset values. Partial data remains in memory but is flagged invalid.
- run_en low in IDLE with prog_valid=1: cpu_run=0 and the CPU pauses. Raising run_en resumes the CPU without a reset pulse.

Test Plan:
- Good load: A5, 03, 11, 22, 33, CC (sum 0x66+0xCC=0x132 -> 0x32, bad). Use csum 9A instead -> mem[0..2]=11,22,33, one cycle of cpu_reset=1, prog_valid=1, cpu_run=1 with run_en=1, fetch_addr=1 -> fetch_data=22.
- Bad checksum: A5, 02, 01, 02, 00 -> load_err=1, prog_valid=0, cpu_run=0, cpu_reset never pulses. A following good frame clears load_err on its A5.
- Length 0: A5, 00, then 256 bytes valued i, then csum (two's complement of 0x80 = 0x80) -> mem[i]=i for all i, addr wraps to 0, prog_valid=1.
- Junk and payload sync: 00, FF before A5 are ignored. Frame A5, 01, A5, 5B -> mem[0]=A5, success.
- Timeout: A5, 02, 10, then idle TIMEOUT cycles -> load_err=1, state IDLE, mem[0]=10, prog_valid=0. Repeat with rx_valid held low while rx_ready stalls nothing else.
- Backpressure/reset: hold rx_valid during START and check rx_ready=0 with the byte not consumed. Drive reset=0 mid-DATA -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/overture_program_loader.sv
// Overture program store writer: fills the 256x8 program memory from a framed byte stream
// and holds the CPU halted until a complete, checksum-verified program has been received.
module overture_program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic [7:0] fetch_addr,
  output logic [7:0] fetch_data,
  input  logic       run_en,
  output logic       cpu_run,
  output logic       cpu_reset,
  output logic       prog_valid,
  output logic       busy,
  output logic       load_err
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StStart} state_e;

  state_e            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [8:0]        remaining_q, remaining_d;
  logic [7:0]        sum_q, sum_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              prog_valid_q, prog_valid_d;
  logic              load_err_q, load_err_d;
  logic              mem_we;
  logic              accept;
  logic [7:0]        csum_total;

  logic [7:0] mem [256];

  assign rx_ready   = (state_q != StStart);
  assign accept     = rx_valid & rx_ready;
  assign csum_total = sum_q + rx_data;

  assign fetch_data = mem[fetch_addr];
  assign prog_valid = prog_valid_q;
  assign load_err   = load_err_q;
  assign busy       = (state_q != StIdle);
  assign cpu_reset  = (state_q == StStart);
  assign cpu_run    = prog_valid_q & run_en & (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    sum_d        = sum_q;
    timer_d      = '0;
    prog_valid_d = prog_valid_q;
    load_err_d   = load_err_q;
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && rx_data == SYNC_BYTE) begin
          load_err_d   = 1'b0;
          prog_valid_d = 1'b0;
          addr_d       = '0;
          sum_d        = '0;
          state_d      = StLen;
        end
      end
      StLen, StData, StCsum: begin
        if (accept) begin
          if (state_q == StLen) begin
            // A length byte of zero encodes a full 256-byte frame.
            remaining_d = {rx_data == 8'd0, rx_data};
            state_d     = StData;
          end else if (state_q == StData) begin
            mem_we      = 1'b1;
            sum_d       = sum_q + rx_data;
            addr_d      = addr_q + 8'd1;
            remaining_d = remaining_q - 9'd1;
            if (remaining_q == 9'd1) state_d = StCsum;
          end else if (csum_total == 8'd0) begin
            prog_valid_d = 1'b1;
            state_d      = StStart;
          end else begin
            load_err_d = 1'b1;
            state_d    = StIdle;
          end
        end else if (timer_q == TimerW'(TIMEOUT)) begin
          load_err_d   = 1'b1;
          prog_valid_d = 1'b0;
          state_d      = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StStart: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      remaining_q  <= '0;
      sum_q        <= '0;
      timer_q      <= '0;
      prog_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      sum_q        <= sum_d;
      timer_q      <= timer_d;
      prog_valid_q <= prog_valid_d;
      load_err_q   <= load_err_d;
    end
  end

  // Program memory is deliberately not reset; prog_valid guards its contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= rx_data;
  end

endmodule

// File: tb/tb_overture_program_loader.sv
// Randomized self-checking bench for overture_program_loader against a frame-level model.
module tb_overture_program_loader;

  localparam int unsigned Timeout = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready;
  logic [7:0] fetch_addr = 8'h00;
  logic [7:0] fetch_data;
  logic       run_en = 1'b1;
  logic       cpu_run, cpu_reset, prog_valid, busy, load_err;

  overture_program_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .run_en(run_en), .cpu_run(cpu_run),
    .cpu_reset(cpu_reset), .prog_valid(prog_valid), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the frame-level behaviour.
  logic [7:0] mem_m [256];
  logic       valid_m = 1'b0;
  logic       err_m = 1'b0;
  int         pulses_m = 0;
  logic [7:0] payload [$];

  int pulses = 0;
  int overlap = 0;
  always @(posedge clk) begin
    if (cpu_reset) pulses++;
    if (cpu_reset && cpu_run) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns #1 after the edge that transfers it.
  task automatic send(input logic [7:0] b, input int max_gap);
    int n = 0;
    tick(max_gap == 0 ? 0 : $urandom_range(max_gap, 0));
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) check("rx_ready_stuck", 32'(rx_ready), 32'd1);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
    fetch_addr = a;
    #1;
    d = fetch_data;
  endtask

  // Sends SYNC, length, the global payload and csum; updates the model from the frame rules.
  task automatic send_frame(input logic [7:0] csum, input int max_gap);
    int unsigned s = 0;
    send(8'hA5, max_gap);
    send(8'(payload.size()), max_gap);
    foreach (payload[i]) begin
      send(payload[i], max_gap);
      mem_m[i] = payload[i];
      s += payload[i];
    end
    send(csum, max_gap);
    if (((s + csum) % 256) == 0) begin
      valid_m = 1'b1;
      err_m   = 1'b0;
      pulses_m++;
    end else begin
      valid_m = 1'b0;
      err_m   = 1'b1;
    end
  endtask

  task automatic check_after(input string tag);
    logic [7:0] d;
    tick(2);
    check({tag, "_prog_valid"}, 32'(prog_valid), 32'(valid_m));
    check({tag, "_load_err"}, 32'(load_err), 32'(err_m));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cpu_run"}, 32'(cpu_run), 32'(valid_m & run_en));
    check({tag, "_pulses"}, 32'(pulses), 32'(pulses_m));
    foreach (payload[i]) begin
      read_mem(8'(i), d);
      check({tag, "_mem"}, 32'(d), 32'(mem_m[i]));
    end
  endtask

  function automatic logic [7:0] good_csum();
    int unsigned s = 0;
    foreach (payload[i]) s += payload[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  initial begin
    logic [7:0] d;
    int unsigned s;
    #3;
    check("rst_prog_valid", 32'(prog_valid), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    #9 reset = 1'b1;
    tick(2);

    // Good load, holding the next byte through START to see backpressure.
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h9A, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd0);
    check("start_cpu_run", 32'(cpu_run), 32'd0);
    tick(1);
    check("after_start_rx_ready", 32'(rx_ready), 32'd1);
    check("after_start_cpu_run", 32'(cpu_run), 32'd1);
    rx_valid = 1'b0;
    check_after("good");
    read_mem(8'd1, d);
    check("fetch_1", 32'(d), 32'h22);
    run_en = 1'b0;
    #1 check("pause_cpu_run", 32'(cpu_run), 32'd0);
    run_en = 1'b1;
    #1 check("resume_cpu_run", 32'(cpu_run), 32'd1);

    // Bad checksum, then a good frame clears the error on its SYNC.
    payload = '{8'h01, 8'h02};
    send_frame(8'h00, 1);
    check_after("badcsum");
    send(8'hA5, 0);
    check("resync_load_err", 32'(load_err), 32'd0);
    check("resync_prog_valid", 32'(prog_valid), 32'd0);
    send(8'h01, 0);
    send(8'h44, 0);
    send(8'hBC, 0);
    mem_m[0] = 8'h44;
    valid_m = 1'b1;
    err_m = 1'b0;
    pulses_m++;
    payload = '{8'h44};
    check_after("recover");

    // Length zero means 256 bytes.
    payload = {};
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    send(8'hA5, 0);
    send(8'h00, 0);
    foreach (payload[i]) begin
      send(payload[i], 0);
      mem_m[i] = payload[i];
    end
    send(8'h80, 0);
    valid_m = 1'b1;
    err_m = 1'b0;
    pulses_m++;
    check_after("len256");

    // Junk before SYNC is dropped; SYNC value inside DATA is payload.
    send(8'h00, 0);
    send(8'hFF, 0);
    payload = '{8'hA5};
    send_frame(8'h5B, 0);
    check_after("junk_sync");

    // Timeout mid-DATA.
    send(8'hA5, 0);
    send(8'h02, 0);
    send(8'h10, 0);
    mem_m[0] = 8'h10;
    tick(Timeout - 1);
    check("timeout_early_err", 32'(load_err), 32'd0);
    check("timeout_early_busy", 32'(busy), 32'd1);
    tick(2);
    valid_m = 1'b0;
    err_m = 1'b1;
    payload = '{8'h10};
    check_after("timeout");

    // Asynchronous reset mid-DATA.
    send(8'hA5, 0);
    send(8'h04, 0);
    send(8'h01, 0);
    mem_m[0] = 8'h01;
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_prog_valid", 32'(prog_valid), 32'd0);
    check("arst_load_err", 32'(load_err), 32'd0);
    check("arst_rx_ready", 32'(rx_ready), 32'd1);
    check("arst_cpu_run", 32'(cpu_run), 32'd0);
    #3 reset = 1'b1;
    valid_m = 1'b0;
    err_m = 1'b0;
    payload = '{8'h01};
    check_after("arst");

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      int n_junk = $urandom_range(2, 0);
      for (int j = 0; j < n_junk; j++) begin
        logic [7:0] jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        send(jb, 2);
      end
      payload = {};
      for (int i = 0; i < int'($urandom_range(12, 1)); i++) payload.push_back(8'($urandom));
      run_en = 1'($urandom);
      s = $urandom_range(2, 0);
      send_frame(s == 0 ? good_csum() + 8'($urandom_range(255, 1)) : good_csum(), 2);
      check_after("rand");
    end

    check("reset_run_overlap", 32'(overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
